// File: rtl/debounce_timer_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : debounce_timer_scheduler
// Purpose  : Shared prescaled debounce timers plus round-robin event queue for
//            N debouncer channels, delivered over a valid/ready handshake.
// Revision : 1.0  initial release
// ============================================================================
module debounce_timer_scheduler #(
    parameter int N_CH           = 4,
    parameter int TICK_DIV       = 50000,
    parameter int DEBOUNCE_TICKS = 20,
    parameter int ID_W           = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_CH-1:0] timer_run,
    output logic [N_CH-1:0] timer_done,
    input  logic [N_CH-1:0] debounced,
    output logic            evt_valid,
    input  logic            evt_ready,
    output logic [ID_W-1:0] evt_id,
    output logic            evt_press,
    output logic [N_CH-1:0] ovf,
    input  logic            ovf_clr
);

    localparam int c_PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int c_CNT_W = $clog2(DEBOUNCE_TICKS + 1);

    logic [c_PRE_W-1:0] r_presc;
    logic               w_tick;

    logic [N_CH-1:0]    r_prev;
    logic [N_CH-1:0]    r_pend;
    logic [N_CH-1:0]    r_ptype;
    logic [N_CH-1:0]    r_ovf;
    logic [N_CH-1:0]    w_edge;
    logic [N_CH-1:0]    w_take;
    logic [N_CH-1:0]    w_ovf_set;

    logic               r_valid;
    logic [ID_W-1:0]    r_id;
    logic               r_press;
    logic [ID_W-1:0]    r_rr;

    logic               w_gnt_vld;
    logic [ID_W-1:0]    w_gnt;
    logic [ID_W-1:0]    w_cand;
    logic [ID_W-1:0]    w_rr_nxt;
    logic               w_load;

    assign w_tick = (r_presc == c_PRE_W'(TICK_DIV - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_presc <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    // One saturating tick counter per channel; a low timer_run clears it.
    generate
        for (genvar g = 0; g < N_CH; g++) begin : g_ch
            logic [c_CNT_W-1:0] r_cnt;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_cnt <= '0;
                end else if (!timer_run[g]) begin
                    r_cnt <= '0;
                end else if (w_tick && (r_cnt < c_CNT_W'(DEBOUNCE_TICKS))) begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end

            assign timer_done[g] = timer_run[g] && (r_cnt == c_CNT_W'(DEBOUNCE_TICKS));
        end
    endgenerate

    // First pending channel at or after the round-robin pointer.
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt     = '0;
        w_cand    = '0;
        for (int i = 0; i < N_CH; i++) begin
            w_cand = ID_W'((int'(r_rr) + i) % N_CH);
            if (!w_gnt_vld && r_pend[w_cand]) begin
                w_gnt_vld = 1'b1;
                w_gnt     = w_cand;
            end
        end
    end

    assign w_load   = (!r_valid || evt_ready) && w_gnt_vld;
    assign w_rr_nxt = (w_gnt == ID_W'(N_CH - 1)) ? '0 : w_gnt + 1'b1;

    always_comb begin
        w_take = '0;
        if (w_load) begin
            w_take[w_gnt] = 1'b1;
        end
    end

    // A slot being granted this cycle counts as empty, so a fresh edge is not an overflow.
    assign w_edge    = r_prev ^ debounced;
    assign w_ovf_set = w_edge & r_pend & ~w_take;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_prev  <= '0;
            r_pend  <= '0;
            r_ptype <= '0;
            r_ovf   <= '0;
        end else begin
            r_prev  <= debounced;
            r_pend  <= w_edge | (r_pend & ~w_take);
            r_ptype <= (w_edge & debounced) | (~w_edge & r_ptype);
            r_ovf   <= (ovf_clr ? '0 : r_ovf) | w_ovf_set;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_id    <= '0;
            r_press <= 1'b0;
            r_rr    <= '0;
        end else if (w_load) begin
            r_valid <= 1'b1;
            r_id    <= w_gnt;
            r_press <= r_ptype[w_gnt];
            r_rr    <= w_rr_nxt;
        end else if (evt_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign evt_valid = r_valid;
    assign evt_id    = r_id;
    assign evt_press = r_press;
    assign ovf       = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_debounce_timer_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_debounce_timer_scheduler
// Purpose  : Self-checking bench: timer checks, table-driven event bursts with
//            a scoreboard, and stall / same-cycle / reset corner sequences.
// Revision : 1.0  initial release
// ============================================================================
module tb_debounce_timer_scheduler;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] timer_run;
    logic [3:0] timer_done;
    logic [3:0] debounced;
    logic       evt_valid;
    logic       evt_ready;
    logic [1:0] evt_id;
    logic       evt_press;
    logic [3:0] ovf;
    logic       ovf_clr;

    always #5 clk = ~clk;

    debounce_timer_scheduler #(
        .N_CH          (4),
        .TICK_DIV      (4),
        .DEBOUNCE_TICKS(3),
        .ID_W          (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .timer_run (timer_run),
        .timer_done(timer_done),
        .debounced (debounced),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_id    (evt_id),
        .evt_press (evt_press),
        .ovf       (ovf),
        .ovf_clr   (ovf_clr)
    );

    typedef struct packed {
        logic [3:0] deb;
        logic [2:0] n;
        logic [7:0] ids;
        logic [3:0] prs;
    } vec_t;

    int         errors = 0;
    int         checks = 0;
    logic [2:0] sb[$];
    logic [2:0] m_exp;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Every accepted event must match the oldest expectation.
    always @(negedge clk) begin
        if (!reset && evt_valid && evt_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_evt: got id=%0d press=%0d expected none", evt_id, evt_press);
            end else begin
                m_exp = sb.pop_front();
                chk("evt", {29'b0, evt_id, evt_press}, {29'b0, m_exp});
            end
        end
    end

    vec_t tbl[8];
    int   lat;

    initial begin
        tbl[0] = '{deb: 4'b0100, n: 3'd1, ids: 8'h02, prs: 4'b0001};
        tbl[1] = '{deb: 4'b0000, n: 3'd1, ids: 8'h02, prs: 4'b0000};
        tbl[2] = '{deb: 4'b1000, n: 3'd1, ids: 8'h03, prs: 4'b0001};
        tbl[3] = '{deb: 4'b0000, n: 3'd1, ids: 8'h03, prs: 4'b0000};
        tbl[4] = '{deb: 4'b1111, n: 3'd4, ids: 8'hE4, prs: 4'b1111};
        tbl[5] = '{deb: 4'b1101, n: 3'd1, ids: 8'h01, prs: 4'b0000};
        tbl[6] = '{deb: 4'b0010, n: 3'd4, ids: 8'h4E, prs: 4'b1000};
        tbl[7] = '{deb: 4'b0000, n: 3'd1, ids: 8'h01, prs: 4'b0000};

        reset     = 1'b1;
        timer_run = 4'b0000;
        debounced = 4'b0000;
        evt_ready = 1'b1;
        ovf_clr   = 1'b0;
        cyc(3);
        chk("rst_valid", evt_valid, 0);
        chk("rst_payload", {evt_id, evt_press}, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_done", timer_done, 0);

        // Timer: ch0 from prescaler phase 0, ch1 from phase 2.
        reset     = 1'b0;
        timer_run = 4'b0001;
        for (int k = 1; k <= 21; k++) begin
            cyc(1);
            if (k == 2)  timer_run = 4'b0011;
            if (k == 11) chk("done_c11", timer_done, 4'b0000);
            if (k == 12) chk("done_c12", timer_done, 4'b0011);
            if (k == 19) chk("done_sat", timer_done, 4'b0011);
            if (k == 20) begin
                timer_run = 4'b0010;
                #1;
                chk("done_drop", timer_done, 4'b0010);
            end
            if (k == 21) begin
                timer_run = 4'b0011;
                #1;
                chk("cnt_cleared", timer_done, 4'b0010);
            end
        end
        timer_run = 4'b0000;
        cyc(1);

        // Table-driven edges with full-throughput drain.
        for (int v = 0; v < 8; v++) begin
            debounced = tbl[v].deb;
            for (int k = 0; k < int'(tbl[v].n); k++)
                sb.push_back({tbl[v].ids[2*k +: 2], tbl[v].prs[k]});
            lat = 0;
            for (int c = 1; c <= 10; c++) begin
                cyc(1);
                if (evt_valid) begin
                    lat = c;
                    break;
                end
            end
            chk("latency", lat, 2);
            cyc(int'(tbl[v].n));
            chk("valid_drop", evt_valid, 0);
            chk("sb_empty", sb.size(), 0);
        end

        // Stall with overwrite on ch1.
        debounced = 4'b0010;
        sb.push_back({2'd1, 1'b1});
        cyc(4);
        evt_ready = 1'b0;
        debounced = 4'b0000;
        sb.push_back({2'd1, 1'b0});
        cyc(3);
        chk("stall_valid", evt_valid, 1);
        chk("stall_payload", {evt_id, evt_press}, 3'b010);
        debounced = 4'b0010;
        cyc(1);
        debounced = 4'b0000;
        cyc(2);
        chk("ovf_set", ovf, 4'b0010);
        chk("stall_hold", {evt_valid, evt_id, evt_press}, 4'b1010);
        sb.push_back({2'd1, 1'b0});
        evt_ready = 1'b1;
        cyc(4);
        chk("stall_drain", sb.size(), 0);
        chk("stall_valid_drop", evt_valid, 0);
        ovf_clr = 1'b1;
        cyc(1);
        ovf_clr = 1'b0;
        chk("ovf_clr", ovf, 0);

        // Edge on ch3 in the same cycle its slot is granted.
        evt_ready = 1'b0;
        debounced = 4'b1000;
        sb.push_back({2'd3, 1'b1});
        cyc(3);
        debounced = 4'b0000;
        sb.push_back({2'd3, 1'b0});
        cyc(2);
        evt_ready = 1'b1;
        debounced = 4'b1000;
        sb.push_back({2'd3, 1'b1});
        cyc(5);
        chk("same_clk_drain", sb.size(), 0);
        chk("same_clk_ovf", ovf, 0);

        // Reset mid-operation with one event held and three pending.
        evt_ready = 1'b0;
        debounced = 4'b0111;
        cyc(4);
        chk("pre_rst_valid", evt_valid, 1);
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk("async_rst", {evt_valid, evt_id, evt_press, ovf}, 0);
        cyc(2);
        reset = 1'b0;
        sb.push_back({2'd0, 1'b1});
        sb.push_back({2'd1, 1'b1});
        sb.push_back({2'd2, 1'b1});
        evt_ready = 1'b1;
        cyc(8);
        chk("post_rst_drain", sb.size(), 0);
        chk("post_rst_idle", evt_valid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
